// File: rtl/fetch_pc.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time and
// hands (pc, instr) to decode. Optional counters enabled by FETCH_PERF_EN.
module fetch_pc #(
    parameter int unsigned           XLEN      = 32,
    parameter logic [XLEN-1:0]       RESET_VEC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            misalign_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            drop;
    logic            req_valid;

    logic redir_ok;
    logic redir_bad;
    logic req_fire;
    logic if_fire;

    assign redir_ok  = redirect_valid & (redirect_target[1:0] == 2'b00);
    assign redir_bad = redirect_valid & (redirect_target[1:0] != 2'b00);
    assign req_fire  = req_valid & imem_req_ready;
    assign if_fire   = if_valid & if_ready;

    // Request outputs come straight from registers; no path from redirect_valid.
    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_REQ;
            pc           <= RESET_VEC;
            req_pc       <= '0;
            drop         <= 1'b0;
            req_valid    <= 1'b0;
            if_valid     <= 1'b0;
            if_pc        <= '0;
            if_instr     <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redir_bad;
            case (state)
                S_REQ: begin
                    if (redir_ok) begin
                        pc <= redirect_target;
                        if (req_fire) begin
                            // Old address already left; its data must be discarded.
                            drop      <= 1'b1;
                            req_valid <= 1'b0;
                            state     <= S_WAIT;
                        end else begin
                            req_valid <= 1'b1;
                        end
                    end else if (req_fire) begin
                        req_pc    <= pc;
                        req_valid <= 1'b0;
                        state     <= S_WAIT;
                    end else begin
                        req_valid <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (redir_ok) begin
                        pc <= redirect_target;
                        if (imem_rsp_valid) begin
                            // The response in flight is the wrong-path one; refetch now.
                            drop      <= 1'b0;
                            req_valid <= 1'b1;
                            state     <= S_REQ;
                        end else begin
                            drop <= 1'b1;
                        end
                    end else if (imem_rsp_valid) begin
                        if (drop) begin
                            drop      <= 1'b0;
                            req_valid <= 1'b1;
                            state     <= S_REQ;
                        end else begin
                            if_pc    <= req_pc;
                            if_instr <= imem_rsp_data;
                            if_valid <= 1'b1;
                            pc       <= req_pc + PC_STEP;
                            state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (redir_ok) begin
                        pc        <= redirect_target;
                        if_valid  <= 1'b0;
                        req_valid <= 1'b1;
                        state     <= S_REQ;
                    end else if (if_fire) begin
                        if_valid  <= 1'b0;
                        req_valid <= 1'b1;
                        state     <= S_REQ;
                    end
                end
                default: begin
                    state     <= S_REQ;
                    req_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic fetched_evt;
    logic flushed_evt;

    // A squash in HOLD wins over a simultaneous decode handshake.
    assign fetched_evt = if_fire & ~((state == S_HOLD) & redir_ok);
    assign flushed_evt = ((state == S_WAIT) & imem_rsp_valid & (drop | redir_ok))
                       | ((state == S_HOLD) & redir_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (fetched_evt) perf_fetched <= perf_fetched + 32'd1;
            if (flushed_evt) perf_flushed <= perf_flushed + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: sequential fetch, redirects in each state,
// backpressure, misaligned target, PC wrap and asynchronous reset.
module tb_fetch_pc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready = 1'b1;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        misalign_err;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_cyc = 0;
    int mem_lat = 1;
    int mem_cnt = 0;
    logic [31:0] rsp_addr = '0;

    fetch_pc #(
        .XLEN(32),
        .RESET_VEC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .if_valid(if_valid),
        .if_ready(if_ready),
        .if_pc(if_pc),
        .if_instr(if_instr),
        .misalign_err(misalign_err)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // Memory with programmable latency; a pending response is delivered even across reset.
    assign imem_rsp_data = mem_word(rsp_addr);
    always @(posedge clk) begin
        imem_rsp_valid <= 1'b0;
        if (imem_req_valid && imem_req_ready) begin
            rsp_addr <= imem_req_addr;
            if (mem_lat <= 1) imem_rsp_valid <= 1'b1;
            else mem_cnt <= mem_lat - 1;
        end else if (mem_cnt > 0) begin
            if (mem_cnt == 1) imem_rsp_valid <= 1'b1;
            mem_cnt <= mem_cnt - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag, input logic [31:0] addr);
        int n = 0;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("%s_req_valid", tag), 32'(imem_req_valid), 32'd1);
        check($sformatf("%s_req_addr", tag), imem_req_addr, addr);
    endtask

    task automatic wait_if(input string tag, input logic [31:0] pc);
        int n = 0;
        while (if_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check($sformatf("%s_if_valid", tag), 32'(if_valid), 32'd1);
        check($sformatf("%s_if_pc", tag), if_pc, pc);
        check($sformatf("%s_if_instr", tag), if_instr, mem_word(pc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_req_addr", imem_req_addr, 32'h0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        rst_n = 1'b1;

        tick();
        check("first_req_valid", 32'(imem_req_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            wait_req($sformatf("seq%0d", i), 32'(i * 4));
            wait_if($sformatf("seq%0d", i), 32'(i * 4));
            if (i > 0) check("seq_period", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
        end

        mem_lat = 3;
        wait_req("wredir_old", 32'h10);
        tick();
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        tick();
        redirect_valid = 1'b0;
        mem_lat = 1;
        check("wredir_no_req", 32'(imem_req_valid), 32'd0);
        wait_req("wredir_new", 32'h100);
        check("wredir_no_if", 32'(if_valid), 32'd0);
        wait_if("wredir", 32'h100);

        wait_req("rredir_old", 32'h104);
        redirect_valid = 1'b1;
        redirect_target = 32'h20;
        tick();
        redirect_valid = 1'b0;
        check("rredir_wait", 32'(imem_req_valid), 32'd0);
        wait_req("rredir_new", 32'h20);
        wait_if("hold", 32'h20);
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        tick();
        redirect_valid = 1'b0;
        check("hredir_if_valid", 32'(if_valid), 32'd0);
        check("hredir_req_valid", 32'(imem_req_valid), 32'd1);
        check("hredir_req_addr", imem_req_addr, 32'h40);
        wait_if("hredir", 32'h40);

        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_if_valid", 32'(if_valid), 32'd1);
            check("bp_if_pc", if_pc, 32'h40);
            check("bp_if_instr", if_instr, mem_word(32'h40));
            check("bp_no_req", 32'(imem_req_valid), 32'd0);
        end
        if_ready = 1'b1;
        wait_req("bp_next", 32'h44);

        redirect_valid = 1'b1;
        redirect_target = 32'h102;
        tick();
        redirect_valid = 1'b0;
        check("mis_pulse", 32'(misalign_err), 32'd1);
        tick();
        check("mis_pulse_end", 32'(misalign_err), 32'd0);
        wait_if("mis", 32'h44);
        wait_req("mis_next", 32'h48);

        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check("stall_redir_valid", 32'(imem_req_valid), 32'd1);
        check("stall_redir_addr", imem_req_addr, 32'hFFFF_FFFC);
        imem_req_ready = 1'b1;
        wait_if("wrap", 32'hFFFF_FFFC);
        wait_req("wrap_next", 32'h0);
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, 32'd8);
        check("perf_flushed", perf_flushed, 32'd3);
`endif

        mem_lat = 3;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req_valid", 32'(imem_req_valid), 32'd0);
        check("arst_req_addr", imem_req_addr, 32'h0);
        check("arst_if_valid", 32'(if_valid), 32'd0);
        check("arst_if_pc", if_pc, 32'h0);
        check("arst_if_instr", if_instr, 32'h0);
`ifdef FETCH_PERF_EN
        check("arst_perf_fetched", perf_fetched, 32'd0);
        check("arst_perf_flushed", perf_flushed, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_lat = 1;
        tick();
        check("restart_req_valid", 32'(imem_req_valid), 32'd1);
        check("restart_req_addr", imem_req_addr, 32'h0);
        check("restart_stale_if", 32'(if_valid), 32'd0);
        tick();
        check("restart_wait_if", 32'(if_valid), 32'd0);
        tick();
        check("restart_if_valid", 32'(if_valid), 32'd1);
        check("restart_if_pc", if_pc, 32'h0);
        check("restart_if_instr", if_instr, mem_word(32'h0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_pc.md
Name: fetch_pc

Overview:
- Instruction-fetch stage of the rv32i core. It owns the program counter, issues word fetches to instruction memory, and hands (pc, instr) pairs to decode over a valid/ready handshake.
- It consumes the redirect produced by the downstream branch/jump conditioner (taken flag plus target) and flushes wrong-path fetches.
- At most one memory request is outstanding at any time.

Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, address/data width. Only 32 is supported.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_target  in  XLEN  new PC from the conditioner.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  XLEN  word address (bits [1:0] = 0).
- imem_rsp_valid  in  1  fetch data returned; one cycle, no backpressure.
- imem_rsp_data  in  32  fetched instruction.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts.
- if_pc  out  XLEN  PC of if_instr.
- if_instr  out  32  instruction word.
- misalign_err  out  1  one-cycle pulse on a misaligned redirect target.

Behaviour:
- Reset (async assert, synchronous-release use):
  - pc = RESET_VEC; state = REQ.
  - imem_req_valid = 0, if_valid = 0, if_pc = 0, if_instr = 0, misalign_err = 0, drop = 0.
- FSM states: REQ, WAIT, HOLD.
- REQ:
  - imem_req_valid = 1, imem_req_addr = pc.
  - On imem_req_ready, latch req_pc = pc and go to WAIT.
  - The first request is visible in the first cycle after rst_n rises.
- WAIT:
  - On imem_rsp_valid with drop = 0: register if_pc = req_pc and if_instr = imem_rsp_data, set if_valid, set pc = req_pc + 4, go to HOLD.
  - On imem_rsp_valid with drop = 1: discard the data, clear drop, go to REQ. pc has already been updated by the redirect.
  - A response arriving in the same cycle as a redirect is discarded.
- HOLD:
  - if_valid = 1, and if_pc/if_instr are stable until handshake.
  - On if_valid & if_ready: clear if_valid and go to REQ. The next request appears the following cycle.
- Latency: request accepted in cycle N, response in cycle N+k, if_valid in cycle N+k+1.
- Redirect (redirect_valid = 1, redirect_target[1:0] = 0): highest priority, applied on the next edge.
  - pc = redirect_target.
  - REQ: if imem_req_ready is high the same cycle, the old address was issued; go to WAIT with drop = 1. Otherwise stay in REQ with the new pc.
  - WAIT: set drop = 1 and stay in WAIT.
  - HOLD: clear if_valid even if if_ready is high (the instruction is squashed) and go to REQ.
- Misaligned redirect (redirect_target[1:0] != 0):
  - The redirect is ignored and misalign_err pulses high for exactly one cycle.
  - Fetch continues sequentially.
- Arithmetic: pc + 4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000); no flag is raised.
- Reset mid-operation: all state returns to reset values immediately. Any in-flight response arriving after reset is ignored, because state is REQ, not WAIT.
- imem_req_addr and imem_req_valid depend only on registered state (no combinational path from redirect_valid).

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output perf_fetched (32 bit): increments on each if_valid & if_ready handshake.
  - Adds output perf_flushed (32 bit): increments on each dropped response or HOLD squash.
  - Both reset to 0, wrap at 2^32, and increment simultaneously when both events occur in one cycle.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- Reset then sequential fetch: RESET_VEC = 0, imem_req_ready = 1, 1-cycle memory, if_ready = 1 -> addresses 0, 4, 8, 12 issued; if_pc/if_instr pairs match in order; one instruction every 3 cycles.
- Redirect during WAIT: request at 0x10 outstanding, redirect to 0x100 -> 0x10 response dropped, next request is 0x100, if_pc = 0x100, perf_flushed = 1 (with FETCH_PERF_EN).
- Redirect in HOLD with if_ready = 1 in the same cycle: holding pc 0x20, target 0x40 -> no handshake counted, if_valid low next cycle, next request is 0x40.
- Backpressure: if_ready = 0 for 5 cycles -> if_valid, if_pc, if_instr stable; no new imem request issued.
- Misaligned target 0x102 -> misalign_err high for 1 cycle, pc continues +4, no flush.
- Wrap and async reset: pc = 0xFFFF_FFFC -> next request is 0x0; asserting rst_n low mid-WAIT -> outputs zero immediately, fetch restarts at RESET_VEC.
